// File: rtl/fifo_pack_reader_if.sv
// Signal bundle between a FIFO read port, the packer and the wide downstream stream.
// out_* stream: a beat transfers on a cycle where out_valid && out_ready; while out_valid=1 and
// out_ready=0, out_data/out_keep/out_valid hold. FIFO side: in_rd_en pops in_dout only when in_empty=0.
interface fifo_pack_reader_if #(
  parameter int FIFO_DATA_WIDTH = 8,
  parameter int PACK_RATIO      = 4
);
  logic                                  in_rd_en;
  logic [FIFO_DATA_WIDTH-1:0]            in_dout;
  logic                                  in_empty;
  logic                                  flush;
  logic                                  flush_busy;
  logic                                  out_valid;
  logic                                  out_ready;
  logic [FIFO_DATA_WIDTH*PACK_RATIO-1:0] out_data;
  logic [PACK_RATIO-1:0]                 out_keep;
  logic                                  dbg_flushing;

  modport master (
    output in_rd_en, flush_busy, out_valid, out_data, out_keep, dbg_flushing,
    input  in_dout, in_empty, flush, out_ready
  );

  modport slave (
    input  in_rd_en, flush_busy, out_valid, out_data, out_keep, dbg_flushing,
    output in_dout, in_empty, flush, out_ready
  );
endinterface

// File: rtl/fifo_pack_reader.sv
// Pops narrow FIFO words, packs PACK_RATIO of them little-endian into a registered wide beat,
// and can flush a partially assembled beat with a lane-keep mask.
module fifo_pack_reader #(
  parameter int FIFO_DATA_WIDTH = 8,
  parameter int PACK_RATIO      = 4
) (
  input logic                 clock,
  input logic                 reset,
  fifo_pack_reader_if.master  bus
);
  localparam int CW = (PACK_RATIO > 1) ? $clog2(PACK_RATIO) : 1;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  state_t                                       r_state;
  state_t                                       w_state_nxt;
  logic [CW-1:0]                                r_cnt;
  logic [PACK_RATIO-1:0][FIFO_DATA_WIDTH-1:0]   r_lanes;
  logic [PACK_RATIO-1:0][FIFO_DATA_WIDTH-1:0]   w_full_beat;
  logic [FIFO_DATA_WIDTH*PACK_RATIO-1:0]        r_out_data;
  logic [PACK_RATIO-1:0]                        r_out_keep;
  logic [PACK_RATIO-1:0]                        w_part_keep;
  logic                                         r_out_valid;
  logic                                         w_out_free;
  logic                                         w_last;
  logic                                         w_rd_en;
  logic                                         w_flush_done;

  always_comb begin
    w_out_free   = !r_out_valid || bus.out_ready;
    w_last       = (r_cnt == CW'(PACK_RATIO - 1));
    // The final lane may only be popped when the output slot can take the new beat.
    w_rd_en      = !reset && !bus.in_empty && (r_state == ST_RUN) && (!w_last || w_out_free);
    w_flush_done = (r_state == ST_FLUSH) && w_out_free;
    w_full_beat  = r_lanes;
    w_full_beat[PACK_RATIO-1] = bus.in_dout;
    w_part_keep  = '0;
    for (int i = 0; i < PACK_RATIO; i++) begin
      w_part_keep[i] = (i < int'(r_cnt));
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN:   if (bus.flush)   w_state_nxt = ST_FLUSH;
      ST_FLUSH: if (w_flush_done) w_state_nxt = ST_RUN;
      default:  w_state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= ST_RUN;
      r_cnt       <= '0;
      r_lanes     <= '0;
      r_out_data  <= '0;
      r_out_keep  <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (r_out_valid && bus.out_ready) begin
        r_out_valid <= 1'b0;
      end
      if (w_rd_en) begin
        if (w_last) begin
          r_out_data  <= w_full_beat;
          r_out_keep  <= '1;
          r_out_valid <= 1'b1;
          r_cnt       <= '0;
          r_lanes     <= '0;
        end else begin
          r_lanes[r_cnt] <= bus.in_dout;
          r_cnt          <= r_cnt + CW'(1);
        end
      end
      // Unfilled lanes are already zero because the assembly register clears after every beat.
      if (w_flush_done && (r_cnt != '0)) begin
        r_out_data  <= r_lanes;
        r_out_keep  <= w_part_keep;
        r_out_valid <= 1'b1;
        r_cnt       <= '0;
        r_lanes     <= '0;
      end
    end
  end

  assign bus.in_rd_en     = w_rd_en;
  assign bus.flush_busy   = (r_state == ST_FLUSH);
  assign bus.dbg_flushing = r_state;
  assign bus.out_valid    = r_out_valid;
  assign bus.out_data     = r_out_data;
  assign bus.out_keep     = r_out_keep;
endmodule

// File: tb/tb_fifo_pack_reader.sv
// Bench for fifo_pack_reader: FIFO queue model on the read side, beat-level reference model,
// directed scenarios followed by randomized traffic.
module tb_fifo_pack_reader;
  localparam int W = 8;
  localparam int P = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  fifo_pack_reader_if #(.FIFO_DATA_WIDTH(W), .PACK_RATIO(P)) bus();

  fifo_pack_reader #(.FIFO_DATA_WIDTH(W), .PACK_RATIO(P)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [W-1:0]   fifo_q[$];
  logic [W-1:0]   part_q[$];
  logic [W*P-1:0] exp_q[$];
  logic [P-1:0]   exp_keep_q[$];
  bit             m_busy = 1'b0;
  bit             after_reset = 1'b0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      if (n_bad <= 30) $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // A beat is the words popped since the last beat, lane 0 first; keep marks the real lanes.
  task automatic emit_partial();
    logic [W*P-1:0] d;
    logic [P-1:0]   k;
    d = '0;
    k = '0;
    for (int i = 0; i < part_q.size(); i++) begin
      d = d | ((W*P)'(part_q[i]) << (W * i));
      k[i] = 1'b1;
    end
    exp_q.push_back(d);
    exp_keep_q.push_back(k);
    part_q.delete();
  endtask

  task automatic push_word(input logic [W-1:0] v);
    fifo_q.push_back(v);
  endtask

  task automatic run_cycle(input bit rdy, input bit fl, input bit rst);
    bit m_free;
    bit m_pop;
    @(negedge clock);
    reset         = rst;
    bus.out_ready = rdy;
    bus.flush     = fl;
    bus.in_empty  = (fifo_q.size() == 0);
    bus.in_dout   = (fifo_q.size() != 0) ? fifo_q[0] : W'($urandom);
    #1;
    m_free = (exp_q.size() == 0) || rdy;
    m_pop  = !rst && (fifo_q.size() != 0) && !m_busy && ((part_q.size() < P - 1) || m_free);
    check_val("in_rd_en", bus.in_rd_en, m_pop);
    if (!rst) begin
      check_val("flush_busy", bus.flush_busy, m_busy);
      check_val("out_valid", bus.out_valid, exp_q.size() != 0);
      if (exp_q.size() != 0) begin
        check_val("out_data", bus.out_data, exp_q[0]);
        check_val("out_keep", bus.out_keep, exp_keep_q[0]);
      end
      if (after_reset) begin
        check_val("rst_out_data", bus.out_data, 0);
        check_val("rst_out_keep", bus.out_keep, 0);
        after_reset = 1'b0;
      end
    end
    @(posedge clock);
    if (rst) begin
      part_q.delete();
      exp_q.delete();
      exp_keep_q.delete();
      m_busy = 1'b0;
    end else begin
      if ((exp_q.size() != 0) && rdy) begin
        exp_q.delete(0);
        exp_keep_q.delete(0);
      end
      if (m_pop) begin
        part_q.push_back(fifo_q[0]);
        if (part_q.size() == P) emit_partial();
      end
      if (m_busy && m_free) begin
        if (part_q.size() != 0) emit_partial();
        m_busy = 1'b0;
      end else if (fl && !m_busy) begin
        m_busy = 1'b1;
      end
    end
    if (m_pop) fifo_q.delete(0);
    after_reset = rst;
  endtask

  initial begin
    int guard;
    bus.out_ready = 1'b0;
    bus.flush     = 1'b0;
    bus.in_empty  = 1'b1;
    bus.in_dout   = '0;

    repeat (2) run_cycle(1'b1, 1'b0, 1'b1);

    // Basic pack.
    push_word(8'h11); push_word(8'h22); push_word(8'h33); push_word(8'h44);
    repeat (8) run_cycle(1'b1, 1'b0, 1'b0);

    // Streaming 12 words.
    for (int i = 1; i <= 12; i++) push_word(W'(i));
    repeat (16) run_cycle(1'b1, 1'b0, 1'b0);

    // Partial flush, then a new beat starting at lane 0.
    push_word(8'hAA); push_word(8'hBB);
    repeat (3) run_cycle(1'b1, 1'b0, 1'b0);
    run_cycle(1'b1, 1'b1, 1'b0);
    repeat (3) run_cycle(1'b1, 1'b0, 1'b0);
    push_word(8'hCC); push_word(8'hDD); push_word(8'hEE); push_word(8'hFF);
    repeat (6) run_cycle(1'b1, 1'b0, 1'b0);

    // Backpressure with 8 queued words.
    for (int i = 0; i < 8; i++) push_word(W'(8'h30 + i));
    repeat (8) run_cycle(1'b0, 1'b0, 1'b0);
    repeat (6) run_cycle(1'b1, 1'b0, 1'b0);

    // Flush with nothing assembled.
    run_cycle(1'b1, 1'b1, 1'b0);
    repeat (3) run_cycle(1'b1, 1'b0, 1'b0);

    // Flush while a beat is stalled, plus a second pulse while busy.
    for (int i = 0; i < 6; i++) push_word(W'(8'h50 + i));
    repeat (8) run_cycle(1'b0, 1'b0, 1'b0);
    run_cycle(1'b0, 1'b1, 1'b0);
    run_cycle(1'b0, 1'b0, 1'b0);
    run_cycle(1'b0, 1'b1, 1'b0);
    repeat (3) run_cycle(1'b0, 1'b0, 1'b0);
    repeat (4) run_cycle(1'b1, 1'b0, 1'b0);

    // Reset after 3 pops, then a clean beat.
    for (int i = 0; i < 3; i++) push_word(W'(8'h70 + i));
    repeat (3) run_cycle(1'b1, 1'b0, 1'b0);
    run_cycle(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) push_word(W'(8'h80 + i));
    repeat (6) run_cycle(1'b1, 1'b0, 1'b0);

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 9) < 6) push_word(W'($urandom));
      run_cycle($urandom_range(0, 9) < 7, $urandom_range(0, 15) == 0, $urandom_range(0, 499) == 0);
    end

    // Drain everything still queued or assembled.
    guard = 0;
    while (((fifo_q.size() != 0) || m_busy) && (guard < 4000)) begin
      run_cycle(1'b1, 1'b0, 1'b0);
      guard++;
    end
    check_val("drain_bound", guard < 4000, 1);
    run_cycle(1'b1, 1'b1, 1'b0);
    repeat (5) run_cycle(1'b1, 1'b0, 1'b0);
    check_val("drain_empty", exp_q.size() + part_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/fifo_pack_reader.md
Name: fifo_pack_reader

Overview:
- Single-clock read-side consumer for the team's FIFO read port (rd_en / dout / empty).
- When empty=0, dout holds the head word. Asserting rd_en for one cycle consumes that word.
- Pops narrow FIFO words, packs PACK_RATIO of them little-endian into one wide beat, and presents each beat on a registered valid/ready stream.
- Provides a flush request that emits an incomplete beat with a lane-keep mask. Sits between a FIFO's read side and a wide downstream datapath.

Parameters:
- FIFO_DATA_WIDTH, 8, width of one FIFO word (one lane).
- PACK_RATIO, 4, FIFO words per output beat; legal range >= 1.

Ports:
- clock  input  1  sole clock; FIFO read side is clocked by this same clock.
- reset  input  1  synchronous, active-high reset.
- in_rd_en  output  1  pop strobe to FIFO rd_en.
- in_dout  input  FIFO_DATA_WIDTH  FIFO head word, valid when in_empty=0.
- in_empty  input  1  FIFO empty flag.
- flush  input  1  single-cycle request to emit any partially assembled beat.
- flush_busy  output  1  flush accepted and not yet completed.
- out_valid  output  1  out_data/out_keep hold a beat.
- out_ready  input  1  downstream accepts the beat when out_valid=1.
- out_data  output  FIFO_DATA_WIDTH*PACK_RATIO  packed beat; lane i = bits [(i+1)*W-1 : i*W].
- out_keep  output  PACK_RATIO  lane i carries a real FIFO word.

Behaviour:
- Reset (synchronous, sampled on the clock edge):
  - out_valid=0, out_data=0, out_keep=0, flush_busy=0.
  - Lane counter cnt=0, assembly register cleared.
  - in_rd_en is forced to 0 combinationally while reset=1.
- Output slot free: out_free = !out_valid || out_ready.
- Pop rule (combinational):
  - in_rd_en = !reset && !in_empty && !flush_busy && (cnt < PACK_RATIO-1 || out_free).
  - Pops never occur when in_empty=1.
  - Sustained throughput is one FIFO word per cycle, with no bubble at beat boundaries when out_ready=1.
- Pop with cnt < PACK_RATIO-1:
  - Assembly lane cnt <= in_dout; cnt <= cnt+1.
  - out_* is untouched, except that a handshake (out_valid && out_ready) in the same cycle clears out_valid.
- Pop with cnt = PACK_RATIO-1 (final lane):
  - out_data <= {in_dout, assembled lanes}; out_keep <= all ones; out_valid <= 1.
  - cnt <= 0; assembly register cleared.
  - A same-cycle handshake of the previous beat is permitted: the new beat replaces the old one.
- Handshake without a new beat: out_valid <= 0. out_data and out_keep hold their values; they are don't-care for checking.
- Stall (out_valid=1, out_ready=0): out_data, out_keep and out_valid hold. Pops continue until cnt = PACK_RATIO-1, then stop.
- Latency:
  - A beat is visible on out_* the cycle after its final-lane pop.
  - in_dout is sampled in the pop cycle only.
- Flush:
  - flush=1 while flush_busy=0 sets flush_busy=1 next cycle. The pop in the flush cycle itself still occurs per the pop rule.
  - flush=1 while flush_busy=1 is ignored.
  - While flush_busy=1, no pops occur. The first cycle with out_free=1 completes the flush:
    - If cnt > 0: out_data <= assembled lanes with unfilled lanes zero; out_keep[i]=1 for i < cnt; out_valid <= 1; cnt <= 0.
    - If cnt = 0: no beat is emitted.
    - In both cases flush_busy <= 0.
  - If the flush-cycle pop completes a full beat, the flush then finds cnt=0 and emits nothing.
- PACK_RATIO=1: every pop emits a beat with out_keep=1; flush never emits.
- Counter width: max(1, $clog2(PACK_RATIO)). cnt never exceeds PACK_RATIO-1.
- Reset mid-beat or mid-flush: partial data is discarded and no beat is emitted. The FIFO is not popped during the reset cycle.
- Combinational paths:
  - out_ready -> in_rd_en is permitted.
  - There is no combinational path from in_dout to any output.

Test Plan (W=8, PACK_RATIO=4):
- Basic pack: FIFO preloaded 0x11,0x22,0x33,0x44, out_ready=1 -> in_rd_en high 4 consecutive cycles; one beat out_data=0x44332211, out_keep=4'b1111, out_valid high exactly 1 cycle.
- Streaming: 12 words 0x01..0x0C, out_ready=1 -> 12 back-to-back pops; beats 0x04030201, 0x08070605, 0x0C0B0A09 on consecutive 4-cycle boundaries, no bubble.
- Backpressure: 8 words queued, out_ready=0 -> first beat held stable; exactly 3 further pops then in_rd_en=0; on out_ready=1, 4th pop and handshake occur the same cycle; second beat follows the next cycle.
- Partial flush: pop 0xAA,0xBB, then pulse flush -> flush_busy=1 one cycle; beat out_data=0x0000BBAA, out_keep=4'b0011; cnt returns to 0; subsequent 0xCC starts lane 0.
- Flush edge cases:
  - Flush with cnt=0 -> no beat, flush_busy clears.
  - Flush while a beat is stalled -> flush_busy holds until out_ready=1, no pops meanwhile.
  - Second flush pulse while busy -> ignored.
- Reset mid-operation: reset asserted after 3 pops -> next cycle out_valid=0, out_keep=0, flush_busy=0; after release, next 4 words form a clean beat with no stale lanes.
